ahb_decoder_mux: RTL
====================

AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4, number of mapped slaves (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, read-data width.
REQ-003 SHALL have parameter SLV_BASE, default {32'h4000_0000,32'h3000_0000,32'h2000_0000,32'h1000_0000}, packed NUM_SLV x 32 region bases, slave 0 in the LSBs.
REQ-004 SHALL have parameter SLV_MASK, default {4{32'hF000_0000}}, packed NUM_SLV x 32 compare masks.
REQ-005 SHALL have port H_clk  in  1  single clock, rising edge.
REQ-006 SHALL have port H_rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port H_addr  in  32  address-phase address.
REQ-008 SHALL have port H_trans  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 SHALL have port hsel  out  NUM_SLV  one-hot slave select, address phase.
REQ-010 SHALL have port s_rdata  in  NUM_SLV*DATA_W  packed slave read data.
REQ-011 SHALL have port s_readyout  in  NUM_SLV  per-slave HREADYOUT.
REQ-012 SHALL have port s_resp  in  NUM_SLV  per-slave HRESP (1=ERROR).
REQ-013 SHALL have port H_rdata  out  DATA_W  muxed read data to master.
REQ-014 SHALL have port H_ready  out  1  muxed HREADY to master and all slaves.
REQ-015 SHALL have port H_resp  out  1  muxed HRESP to master.
REQ-016 SHALL have port dec_err_cnt  out  8  saturating count of decode errors.

Function
REQ-017 Slave i SHALL match when (H_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]); combinational, zero latency.
REQ-018 On overlapping matches, the lowest index SHALL win; hsel SHALL be one-hot or all-zero.
REQ-019 hsel SHALL follow H_addr regardless of H_trans; no match SHALL select the internal default slave (hsel all-zero).
REQ-020 A data-phase select register (slave index or DEFAULT) SHALL load the address-phase decode on each H_clk edge where H_ready=1, and hold otherwise.
REQ-021 With a mapped slave selected in the data phase, H_rdata/H_ready/H_resp SHALL equal that slave's s_rdata/s_readyout/s_resp.
REQ-022 The default slave FSM SHALL have states DS_OKAY, DS_ERR1, DS_ERR2.
REQ-023 DS_OKAY -> DS_ERR1 SHALL occur when H_ready=1, decode = DEFAULT and H_trans is NONSEQ or SEQ; otherwise stay.
REQ-024 In DS_ERR1: H_ready=0, H_resp=1; SHALL go unconditionally to DS_ERR2.
REQ-025 In DS_ERR2: H_ready=1, H_resp=1; next state SHALL be DS_ERR1 if a new NONSEQ/SEQ to unmapped space is presented, else DS_OKAY.
REQ-026 In DS_OKAY with DEFAULT selected in the data phase: H_ready=1, H_resp=0 (IDLE/BUSY to unmapped space is zero-wait OKAY).
REQ-027 With DEFAULT selected, H_rdata SHALL be all-zero.
REQ-028 dec_err_cnt SHALL increment on each DS_OKAY/DS_ERR2 -> DS_ERR1 transition and saturate at 8'hFF.
REQ-029 An address phase to a mapped slave presented during DS_ERR2 SHALL be captured normally and the FSM SHALL return to DS_OKAY.

Reset
REQ-030 While H_rst=1: data-phase select = DEFAULT, FSM = DS_OKAY, dec_err_cnt = 0, hence H_ready=1, H_resp=0, H_rdata=0.
REQ-031 Reset asserted mid-error (DS_ERR1/DS_ERR2) SHALL abort the response immediately, with no further ERROR cycle after release.

Structure
REQ-032 HTRANS encodings, the HRESP constants and the FSM state encoding SHALL live in shared package ahb_pkg.
REQ-033 The default-slave FSM and dec_err_cnt SHALL be sub-module ahb_default_slave; decode and muxing remain top-level.

Verification
REQ-034 NONSEQ read 32'h2000_0010, slave1 s_rdata=32'hCAFE_0001, ready=1 -> hsel=4'b0010; next cycle H_rdata=32'hCAFE_0001, H_ready=1, H_resp=0.
REQ-035 NONSEQ 32'h9000_0000 (unmapped) -> hsel=0; H_ready=0/H_resp=1, then H_ready=1/H_resp=1; dec_err_cnt=1.
REQ-036 IDLE 32'h9000_0000 -> H_ready=1, H_resp=0 in the data phase; dec_err_cnt unchanged.
REQ-037 Slave2 holds s_readyout=0 for 3 cycles while the next address is 32'h1000_0000 -> data-phase select stays slave2 until ready; slave0 is selected only afterwards.
REQ-038 Back-to-back unmapped NONSEQ x300 -> continuous ERR1/ERR2 pairs; dec_err_cnt saturates at 8'hFF.
REQ-039 Assert H_rst during DS_ERR1 -> next cycle H_ready=1, H_resp=0, dec_err_cnt=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants: transfer types, response codes and the
// default-slave state encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] DS_OKAY = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    // NONSEQ and SEQ are the only transfer types that demand a response.
    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped address space: two-cycle ERROR response for
// active transfers, zero-wait OKAY otherwise, plus a saturating error count.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hready,
    input  logic       dec_default,
    input  logic [1:0] trans,
    output logic       ready_out,
    output logic       resp_out,
    output logic [7:0] err_cnt
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       err_go;

    assign err_go = dec_default && trans_active(trans);

    always_comb begin
        state_nxt = state;
        case (state)
            DS_OKAY: if (hready && err_go) state_nxt = DS_ERR1;
            DS_ERR1: state_nxt = DS_ERR2;
            DS_ERR2: state_nxt = err_go ? DS_ERR1 : DS_OKAY;
            default: state_nxt = DS_OKAY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DS_OKAY;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == DS_ERR1 && state != DS_ERR1 && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign ready_out = (state != DS_ERR1);
    assign resp_out  = (state == DS_OKAY) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave-to-master response multiplexer with
// an internal default slave for unmapped space.
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int unsigned           NUM_SLV  = 4,
    parameter int unsigned           DATA_W   = 32,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'h4000_0000, 32'h3000_0000,
                                                 32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = {4{32'hF000_0000}}
) (
    input  logic                      H_clk,
    input  logic                      H_rst,
    input  logic [31:0]               H_addr,
    input  logic [1:0]                H_trans,
    output logic [NUM_SLV-1:0]        hsel,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_readyout,
    input  logic [NUM_SLV-1:0]        s_resp,
    output logic [DATA_W-1:0]         H_rdata,
    output logic                      H_ready,
    output logic                      H_resp,
    output logic [7:0]                dec_err_cnt
);

    logic              dec_hit;
    logic [3:0]        dec_idx;
    logic              sel_def;
    logic [3:0]        sel_idx;
    logic [DATA_W-1:0] slv_rdata;
    logic              slv_ready;
    logic              slv_resp;
    logic              ds_ready;
    logic              ds_resp;

    // First match scanning upward gives lowest-index priority on overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        hsel    = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!dec_hit &&
                ((H_addr & SLV_MASK[i*32 +: 32]) ==
                 (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32]))) begin
                dec_hit = 1'b1;
                dec_idx = i[3:0];
                hsel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge H_clk or posedge H_rst) begin
        if (H_rst) begin
            sel_def <= 1'b1;
            sel_idx <= '0;
        end else if (H_ready) begin
            sel_def <= !dec_hit;
            sel_idx <= dec_idx;
        end
    end

    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = HRESP_OKAY;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (sel_idx == i[3:0]) begin
                slv_rdata = s_rdata[i*DATA_W +: DATA_W];
                slv_ready = s_readyout[i];
                slv_resp  = s_resp[i];
            end
        end
    end

    assign H_rdata = sel_def ? '0       : slv_rdata;
    assign H_ready = sel_def ? ds_ready : slv_ready;
    assign H_resp  = sel_def ? ds_resp  : slv_resp;

    ahb_default_slave u_default_slave (
        .clk         (H_clk),
        .rst         (H_rst),
        .hready      (H_ready),
        .dec_default (!dec_hit),
        .trans       (H_trans),
        .ready_out   (ds_ready),
        .resp_out    (ds_resp),
        .err_cnt     (dec_err_cnt)
    );

endmodule
